// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data RAM between the processor (port C)
// and one peripheral master (port P). C has absolute priority over a transparent path.
// P uses a req/gnt handshake and is served in idle RAM cycles.
// Optional build macro: STARVE_GUARD_EN forces a one-cycle P grant after MAX_WAIT
// blocked cycles and stalls C for that cycle. Without it, P can wait behind C forever.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_access,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [ADDR_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_rvalid,
  output logic [DATA_W-1:0] per_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [CNT_W-1:0]  grant_count
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [CNT_W-1:0] WaitLimit = CNT_W'(MAX_WAIT);

  state_e              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                per_rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    grant_count_q;
  logic                force_gnt;

`ifdef STARVE_GUARD_EN
  // P has waited long enough: take the RAM from C for exactly one cycle.
  assign force_gnt = per_req && (state_q == StWait) && (wait_cnt_q == WaitLimit);
`else
  assign force_gnt = 1'b0;
`endif

  assign cpu_stall   = force_gnt;
  assign per_gnt     = per_req && (!cpu_access || force_gnt);
  assign cpu_q       = ram_dout;
  assign per_rvalid  = per_rvalid_q;
  assign grant_count = grant_count_q;

  // RAM data lags its address by one cycle, so the response cycle passes ram_dout straight
  // through. Afterwards the last response is held.
  assign per_rdata = per_rvalid_q ? ram_dout : rdata_q;

  // RAM port mux: whoever owns the cycle drives address, data and a gated write enable.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_data;
    ram_wen  = cpu_access && cpu_wren;
    if (per_gnt) begin
      ram_addr = per_addr;
      ram_din  = per_wdata;
      ram_wen  = per_we;
    end
  end

  // Handshake FSM with wait counter, read-response flag, held read data and grant counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      per_rvalid_q  <= 1'b0;
      rdata_q       <= '0;
      grant_count_q <= '0;
    end else begin
      per_rvalid_q <= per_gnt && !per_we;
      if (per_rvalid_q) begin
        rdata_q <= ram_dout;
      end
      if (per_gnt && (grant_count_q != '1)) begin
        grant_count_q <= grant_count_q + 1'b1;
      end
      unique case (state_q)
        // A response cycle accepts a new request exactly like idle does.
        StIdle, StResp: begin
          if (per_gnt) begin
            if (per_we) state_q <= StIdle;
            else        state_q <= StResp;
          end else if (per_req) begin
            state_q    <= StWait;
            wait_cnt_q <= CNT_W'(1);
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          if (!per_req) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else if (per_gnt) begin
            if (per_we) state_q <= StIdle;
            else        state_q <= StResp;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q != WaitLimit) begin
            // Past the threshold only "reached it" matters, so the count stops there.
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= StIdle;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous-read RAM.
// Build with STARVE_GUARD_EN defined to select forced-grant expectations.
module tb_dmem_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic        cpu_access;
  logic        cpu_wren;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] cpu_q;
  logic        cpu_stall;
  logic        per_req;
  logic        per_we;
  logic [11:0] per_addr;
  logic [31:0] per_wdata;
  logic        per_gnt;
  logic        per_rvalid;
  logic [31:0] per_rdata;
  logic [11:0] ram_addr;
  logic        ram_wen;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [15:0] grant_count;

  int errors = 0;
  int checks = 0;
  int exp_gc = 0;

  logic [31:0] mem [0:4095];

  dmem_port_arbiter #(
    .ADDR_W   (12),
    .DATA_W   (32),
    .MAX_WAIT (4),
    .CNT_W    (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_access  (cpu_access),
    .cpu_wren    (cpu_wren),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .cpu_q       (cpu_q),
    .cpu_stall   (cpu_stall),
    .per_req     (per_req),
    .per_we      (per_we),
    .per_addr    (per_addr),
    .per_wdata   (per_wdata),
    .per_gnt     (per_gnt),
    .per_rvalid  (per_rvalid),
    .per_rdata   (per_rdata),
    .ram_addr    (ram_addr),
    .ram_wen     (ram_wen),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .grant_count (grant_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM, read data one cycle after address, read-before-write.
  always @(posedge clock) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Preload RAM through the processor port.
  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    cpu_access = 1'b1; cpu_wren = 1'b1; cpu_addr = a; cpu_data = d;
    @(negedge clock);
    cpu_access = 1'b0; cpu_wren = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cpu_access = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_data = '0;
    per_req = 1'b0; per_we = 1'b0; per_addr = '0; per_wdata = '0;
    #12;
    checks++;
    if (per_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", per_rvalid); end
    checks++;
    if (per_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", per_rdata); end
    checks++;
    if (grant_count !== 16'h0) begin errors++; $display("FAIL reset_gc: got %0d want 0", grant_count); end
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_single_read;
    @(negedge clock);
    per_req = 1'b1; per_we = 1'b0; per_addr = 12'h010;
    #1;
    checks++;
    if (per_gnt !== 1'b1) begin errors++; $display("FAIL t1_gnt: got %b want 1", per_gnt); end
    checks++;
    if (ram_addr !== 12'h010 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL t1_ram: got addr %h wen %b want 010/0", ram_addr, ram_wen);
    end
    exp_gc++;
    @(negedge clock);
    per_req = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b1 || per_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t1_resp: got v=%b d=%h want 1/deadbeef", per_rvalid, per_rdata);
    end
    checks++;
    if (grant_count !== 16'(exp_gc)) begin errors++; $display("FAIL t1_gc: got %0d want %0d", grant_count, exp_gc); end
    @(negedge clock);
    #1;
    checks++;
    if (per_rvalid !== 1'b0 || per_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t1_hold: got v=%b d=%h want 0/deadbeef", per_rvalid, per_rdata);
    end
  endtask

  // Three blocked cycles keeps below the MAX_WAIT=4 force threshold in either build.
  task automatic test_blocked_read;
    @(negedge clock);
    cpu_access = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h055;
    per_req = 1'b1; per_we = 1'b0; per_addr = 12'h030;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      checks++;
      if (per_gnt !== 1'b0 || ram_addr !== 12'h055 || per_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL t2_block%0d: got gnt=%b addr=%h v=%b want 0/055/0", i, per_gnt, ram_addr, per_rvalid);
      end
    end
    @(negedge clock);
    cpu_access = 1'b0;
    #1;
    checks++;
    if (per_gnt !== 1'b1 || ram_addr !== 12'h030) begin
      errors++; $display("FAIL t2_gnt: got gnt=%b addr=%h want 1/030", per_gnt, ram_addr);
    end
    exp_gc++;
    @(negedge clock);
    per_req = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b1 || per_rdata !== 32'h0BADF00D) begin
      errors++; $display("FAIL t2_resp: got v=%b d=%h want 1/0badf00d", per_rvalid, per_rdata);
    end
    checks++;
    if (grant_count !== 16'(exp_gc)) begin errors++; $display("FAIL t2_gc: got %0d want %0d", grant_count, exp_gc); end
  endtask

  task automatic test_write_then_cpu_read;
    @(negedge clock);
    per_req = 1'b1; per_we = 1'b1; per_addr = 12'h020; per_wdata = 32'h12345678;
    #1;
    checks++;
    if (per_gnt !== 1'b1 || ram_wen !== 1'b1 || ram_din !== 32'h12345678 || ram_addr !== 12'h020) begin
      errors++;
      $display("FAIL t3_wr: got gnt=%b wen=%b din=%h addr=%h want 1/1/12345678/020", per_gnt, ram_wen, ram_din, ram_addr);
    end
    exp_gc++;
    @(negedge clock);
    per_req = 1'b0; per_we = 1'b0;
    cpu_access = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h020;
    #1;
    checks++;
    if (per_rvalid !== 1'b0 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL t3_norv: got v=%b wen=%b want 0/0", per_rvalid, ram_wen);
    end
    @(negedge clock);
    cpu_access = 1'b0;
    #1;
    checks++;
    if (cpu_q !== 32'h12345678) begin errors++; $display("FAIL t3_cpu_q: got %h want 12345678", cpu_q); end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    per_req = 1'b1; per_we = 1'b0; per_addr = 12'h001;
    #1;
    checks++;
    if (per_gnt !== 1'b1) begin errors++; $display("FAIL t4_gnt0: got %b want 1", per_gnt); end
    @(negedge clock);
    per_addr = 12'h002;
    #1;
    checks++;
    if (per_gnt !== 1'b1 || per_rvalid !== 1'b1 || per_rdata !== 32'h0000000A) begin
      errors++; $display("FAIL t4_first: got gnt=%b v=%b d=%h want 1/1/0000000a", per_gnt, per_rvalid, per_rdata);
    end
    exp_gc += 2;
    @(negedge clock);
    per_req = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b1 || per_rdata !== 32'h0000000B) begin
      errors++; $display("FAIL t4_second: got v=%b d=%h want 1/0000000b", per_rvalid, per_rdata);
    end
    @(negedge clock);
    #1;
    checks++;
    if (per_rvalid !== 1'b0) begin errors++; $display("FAIL t4_end: got %b want 0", per_rvalid); end
    checks++;
    if (grant_count !== 16'(exp_gc)) begin errors++; $display("FAIL t4_gc: got %0d want %0d", grant_count, exp_gc); end
  endtask

  task automatic test_starvation;
    logic guard;
    logic exp_force;
`ifdef STARVE_GUARD_EN
    guard = 1'b1;
`else
    guard = 1'b0;
`endif
    @(negedge clock);
    cpu_access = 1'b1; cpu_wren = 1'b0; cpu_addr = 12'h077;
    per_req = 1'b1; per_we = 1'b0; per_addr = 12'h010;
    for (int k = 1; k <= 6; k++) begin
      if (k != 1) @(negedge clock);
      #1;
      exp_force = guard && (k == 5);
      checks++;
      if (per_gnt !== exp_force || cpu_stall !== exp_force) begin
        errors++;
        $display("FAIL t5_cycle%0d: got gnt=%b stall=%b want %b/%b", k, per_gnt, cpu_stall, exp_force, exp_force);
      end
      if (exp_force) exp_gc++;
      if (k == 6) begin
        checks++;
        if (per_rvalid !== guard || (guard && per_rdata !== 32'hDEADBEEF)) begin
          errors++; $display("FAIL t5_resp: got v=%b d=%h want v=%b", per_rvalid, per_rdata, guard);
        end
      end
    end
    @(negedge clock);
    per_req = 1'b0; cpu_access = 1'b0;
    #1;
    checks++;
    if (grant_count !== 16'(exp_gc)) begin errors++; $display("FAIL t5_gc: got %0d want %0d", grant_count, exp_gc); end
  endtask

  task automatic test_reset_in_resp;
    @(negedge clock);
    cpu_access = 1'b0; per_req = 1'b1; per_we = 1'b0; per_addr = 12'h001;
    @(negedge clock);
    per_req = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b1) begin errors++; $display("FAIL t6_pre: got %b want 1", per_rvalid); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b0 || grant_count !== 16'h0 || per_rdata !== 32'h0) begin
      errors++; $display("FAIL t6_async: got v=%b gc=%0d d=%h want 0/0/0", per_rvalid, grant_count, per_rdata);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checks++;
    if (per_rvalid !== 1'b0) begin errors++; $display("FAIL t6_release: got %b want 0", per_rvalid); end
    @(negedge clock);
    per_req = 1'b1; per_addr = 12'h020;
    #1;
    checks++;
    if (per_gnt !== 1'b1) begin errors++; $display("FAIL t6_idle_gnt: got %b want 1", per_gnt); end
    @(negedge clock);
    per_req = 1'b0;
    #1;
    checks++;
    if (per_rvalid !== 1'b1 || per_rdata !== 32'h12345678 || grant_count !== 16'h1) begin
      errors++;
      $display("FAIL t6_after: got v=%b d=%h gc=%0d want 1/12345678/1", per_rvalid, per_rdata, grant_count);
    end
  endtask

  initial begin
    test_reset();
    cpu_write(12'h010, 32'hDEADBEEF);
    cpu_write(12'h030, 32'h0BADF00D);
    cpu_write(12'h001, 32'h0000000A);
    cpu_write(12'h002, 32'h0000000B);
    test_single_read();
    test_blocked_read();
    test_write_then_cpu_read();
    test_back_to_back();
    test_starvation();
    test_reset_in_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
